// File: rtl/se_sram_srw_arbiter.sv
// rtl/se_sram_srw_arbiter.sv - round-robin two-port arbiter in front of a single-port synchronous SRAM
module se_sram_srw_arbiter #(
   parameter int address_width  = 16,
   parameter int data_width     = 8,
   parameter bit clear_on_reset = 1'b1
) (
   input  logic                     sram_clock,
   input  logic                     sram_clock__enable,
   input  logic                     reset_n,
   input  logic                     a_req,
   input  logic                     a_read_not_write,
   input  logic [address_width-1:0] a_address,
   input  logic [data_width-1:0]    a_write_data,
   output logic                     a_ack,
   output logic                     a_rdata_valid,
   output logic [data_width-1:0]    a_rdata,
   input  logic                     b_req,
   input  logic                     b_read_not_write,
   input  logic [address_width-1:0] b_address,
   input  logic [data_width-1:0]    b_write_data,
   output logic                     b_ack,
   output logic                     b_rdata_valid,
   output logic [data_width-1:0]    b_rdata,
   output logic                     busy,
   output logic                     sram_select,
   output logic                     sram_read_not_write,
   output logic                     sram_write_enable,
   output logic [address_width-1:0] sram_address,
   output logic [data_width-1:0]    sram_write_data,
   input  logic [data_width-1:0]    sram_data_out
);

   typedef enum logic {
      st_clear = 1'b0,
      st_run   = 1'b1
   } state_t;

   localparam state_t reset_state = clear_on_reset ? st_clear : st_run;

   state_t                     state_q, state_d;
   logic [address_width-1:0]   clear_addr_q, clear_addr_d;
   logic                       last_grant_q, last_grant_d;
   logic                       rd_pend_a_q, rd_pend_b_q;
   logic                       grant_a, grant_b;

   // State register: reset wins over the clock enable; otherwise advance only on enabled edges
   always_ff @(posedge sram_clock) begin
      if (!reset_n) begin
         state_q      <= reset_state;
         clear_addr_q <= '0;
         last_grant_q <= 1'b1;
         rd_pend_a_q  <= 1'b0;
         rd_pend_b_q  <= 1'b0;
      end else if (sram_clock__enable) begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
         last_grant_q <= last_grant_d;
         rd_pend_a_q  <= grant_a & a_read_not_write;
         rd_pend_b_q  <= grant_b & b_read_not_write;
      end
   end

   // Next state, round-robin grant and SRAM drive; idle cycles park the bus on A's fields
   always_comb begin
      state_d             = state_q;
      clear_addr_d        = clear_addr_q;
      last_grant_d        = last_grant_q;
      grant_a             = 1'b0;
      grant_b             = 1'b0;
      busy                = 1'b0;
      sram_select         = 1'b0;
      sram_read_not_write = 1'b1;
      sram_write_enable   = 1'b0;
      sram_address        = a_address;
      sram_write_data     = a_write_data;

      if (reset_n) begin
         busy = (state_q == st_clear);
         if (sram_clock__enable) begin
            case (state_q)
               st_clear: begin
                  sram_select         = 1'b1;
                  sram_read_not_write = 1'b0;
                  sram_write_enable   = 1'b1;
                  sram_address        = clear_addr_q;
                  sram_write_data     = '0;
                  clear_addr_d        = clear_addr_q + address_width'(1);
                  if (clear_addr_q == {address_width{1'b1}}) begin
                     state_d = st_run;
                  end
               end
               default: begin
                  // On a tie the port that did not win last time goes first
                  if (a_req && (!b_req || last_grant_q)) begin
                     grant_a = 1'b1;
                  end else if (b_req) begin
                     grant_b = 1'b1;
                  end

                  if (grant_a) begin
                     sram_select         = 1'b1;
                     sram_read_not_write = a_read_not_write;
                     sram_write_enable   = !a_read_not_write;
                     sram_address        = a_address;
                     sram_write_data     = a_write_data;
                     last_grant_d        = 1'b0;
                  end else if (grant_b) begin
                     sram_select         = 1'b1;
                     sram_read_not_write = b_read_not_write;
                     sram_write_enable   = !b_read_not_write;
                     sram_address        = b_address;
                     sram_write_data     = b_write_data;
                     last_grant_d        = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign a_ack         = grant_a;
   assign b_ack         = grant_b;
   assign a_rdata_valid = rd_pend_a_q;
   assign b_rdata_valid = rd_pend_b_q;
   assign a_rdata       = sram_data_out;
   assign b_rdata       = sram_data_out;

endmodule

// File: tb/tb_se_sram_srw_arbiter.sv
// tb/tb_se_sram_srw_arbiter.sv - directed-vector bench for se_sram_srw_arbiter with and without clear
module tb_se_sram_srw_arbiter;

   localparam int aw = 7;
   localparam int dw = 8;

   logic          clk = 1'b0;
   logic          en;
   logic          reset_n;
   logic          a_req, a_rnw, b_req, b_rnw;
   logic [aw-1:0] a_addr, b_addr;
   logic [dw-1:0] a_wd, b_wd;

   // clearing instance
   logic          c_a_ack, c_a_valid, c_b_ack, c_b_valid, c_busy;
   logic [dw-1:0] c_a_rdata, c_b_rdata;
   logic          c_sel, c_rnw, c_we;
   logic [aw-1:0] c_addr;
   logic [dw-1:0] c_wd, c_dout;
   logic [dw-1:0] c_mem [0:(1<<aw)-1];

   // non-clearing instance
   logic          n_a_ack, n_a_valid, n_b_ack, n_b_valid, n_busy;
   logic [dw-1:0] n_a_rdata, n_b_rdata;
   logic          n_sel, n_rnw, n_we;
   logic [aw-1:0] n_addr;
   logic [dw-1:0] n_wd, n_dout;
   logic [dw-1:0] n_mem [0:(1<<aw)-1];

   int errors = 0;
   int checks = 0;
   int cnt;
   int acks;

   always #5 clk = ~clk;

   se_sram_srw_arbiter #(.address_width(aw), .data_width(dw), .clear_on_reset(1'b1)) dut_clr (
      .sram_clock(clk), .sram_clock__enable(en), .reset_n(reset_n),
      .a_req(a_req), .a_read_not_write(a_rnw), .a_address(a_addr), .a_write_data(a_wd),
      .a_ack(c_a_ack), .a_rdata_valid(c_a_valid), .a_rdata(c_a_rdata),
      .b_req(b_req), .b_read_not_write(b_rnw), .b_address(b_addr), .b_write_data(b_wd),
      .b_ack(c_b_ack), .b_rdata_valid(c_b_valid), .b_rdata(c_b_rdata),
      .busy(c_busy), .sram_select(c_sel), .sram_read_not_write(c_rnw),
      .sram_write_enable(c_we), .sram_address(c_addr), .sram_write_data(c_wd),
      .sram_data_out(c_dout));

   se_sram_srw_arbiter #(.address_width(aw), .data_width(dw), .clear_on_reset(1'b0)) dut_nclr (
      .sram_clock(clk), .sram_clock__enable(en), .reset_n(reset_n),
      .a_req(a_req), .a_read_not_write(a_rnw), .a_address(a_addr), .a_write_data(a_wd),
      .a_ack(n_a_ack), .a_rdata_valid(n_a_valid), .a_rdata(n_a_rdata),
      .b_req(b_req), .b_read_not_write(b_rnw), .b_address(b_addr), .b_write_data(b_wd),
      .b_ack(n_b_ack), .b_rdata_valid(n_b_valid), .b_rdata(n_b_rdata),
      .busy(n_busy), .sram_select(n_sel), .sram_read_not_write(n_rnw),
      .sram_write_enable(n_we), .sram_address(n_addr), .sram_write_data(n_wd),
      .sram_data_out(n_dout));

   // single-port synchronous SRAM models, clocked with the same enable
   always @(posedge clk) begin
      if (en && c_sel) begin
         if (c_we) c_mem[c_addr] <= c_wd;
         if (c_rnw) c_dout <= c_mem[c_addr];
      end
      if (en && n_sel) begin
         if (n_we) n_mem[n_addr] <= n_wd;
         if (n_rnw) n_dout <= n_mem[n_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << aw); i++) begin
         c_mem[i] = 8'hFF;
         n_mem[i] = 8'hFF;
      end
      c_dout = 8'hFF;
      n_dout = 8'hFF;
      en = 1'b1; reset_n = 1'b0;
      a_req = 1'b1; a_rnw = 1'b1; a_addr = 7'h05; a_wd = 8'h00;
      b_req = 1'b0; b_rnw = 1'b1; b_addr = 7'h00; b_wd = 8'h00;
      step(); step(); #1;

      // outputs forced quiet while in reset
      check("rst_busy", c_busy, 0);
      check("rst_sel", c_sel, 0);
      check("rst_we", c_we, 0);
      check("rst_aack_clr", c_a_ack, 0);
      check("rst_aack_nclr", n_a_ack, 0);
      check("rst_sel_nclr", n_sel, 0);

      reset_n = 1'b1; #1;
      check("clr_busy", c_busy, 1);
      check("clr_aack", c_a_ack, 0);
      check("clr_addr0", c_addr, 0);
      check("clr_we", c_we, 1);
      check("clr_wd", c_wd, 0);
      check("nclr_ack_now", n_a_ack, 1);
      check("nclr_busy", n_busy, 0);

      repeat (64) step();
      #1;
      check("clr_addr40", c_addr, 7'h40);
      check("nclr_pend", n_a_valid, 1);

      // reset mid-clear and with a read pending on the non-clearing instance
      reset_n = 1'b0; a_req = 1'b0;
      step();
      reset_n = 1'b1; #1;
      check("rst2_addr0", c_addr, 0);
      check("rst2_busy", c_busy, 1);
      check("rst2_pend_drop", n_a_valid, 0);
      check("rst2_nclr_busy", n_busy, 0);

      // full clear: 128 busy cycles with A's read held off
      a_req = 1'b1; a_rnw = 1'b1; a_addr = 7'h05; #1;
      cnt = 0; acks = 0;
      while (c_busy && cnt < 300) begin
         cnt++;
         if (c_a_ack) acks++;
         step(); #1;
      end
      check("clear_len", cnt, 128);
      check("clear_noack", acks, 0);
      check("first_ack", c_a_ack, 1);
      check("first_addr", c_addr, 7'h05);
      check("first_rnw", c_rnw, 1);

      // read of cleared word, then write 0x3C @0x10 and read it back
      step();
      a_rnw = 1'b0; a_addr = 7'h10; a_wd = 8'h3C; #1;
      check("rd5_valid", c_a_valid, 1);
      check("rd5_data", c_a_rdata, 8'h00);
      check("wr_ack", c_a_ack, 1);
      check("wr_we", c_we, 1);
      check("wr_addr", c_addr, 7'h10);
      check("wr_data", c_wd, 8'h3C);
      step();
      a_rnw = 1'b1; #1;
      check("rd_ack", c_a_ack, 1);
      check("rd_novalid", c_a_valid, 0);
      step();
      a_req = 1'b0; #1;
      check("rd_valid", c_a_valid, 1);
      check("rd_data", c_a_rdata, 8'h3C);
      check("idle_sel", c_sel, 0);

      // both ports requesting after reset: A writes, B reads, A first
      reset_n = 1'b0;
      a_req = 1'b1; a_rnw = 1'b0; a_addr = 7'h20; a_wd = 8'hA5;
      b_req = 1'b1; b_rnw = 1'b1; b_addr = 7'h20;
      step(); step();
      reset_n = 1'b1; #1;
      check("nclr_alt0_a", n_a_ack, 1);
      check("nclr_alt0_b", n_b_ack, 0);
      step(); #1;
      check("nclr_alt1_a", n_a_ack, 0);
      check("nclr_alt1_b", n_b_ack, 1);

      cnt = 0;
      while (c_busy && cnt < 300) begin
         cnt++;
         step(); #1;
      end
      check("clear2_len", cnt, 127);
      for (int k = 0; k < 4; k++) begin
         check("alt_a", c_a_ack, (k % 2 == 0) ? 1 : 0);
         check("alt_b", c_b_ack, (k % 2 == 1) ? 1 : 0);
         if (k == 2) begin
            check("alt_bvalid", c_b_valid, 1);
            check("alt_bdata", c_b_rdata, 8'hA5);
         end
         step(); #1;
      end

      // B read then three disabled cycles
      a_req = 1'b0; #1;
      check("en_back_ack", c_b_ack, 1);
      step();
      en = 1'b0; #1;
      for (int k = 0; k < 3; k++) begin
         check("dis_ack", c_b_ack, 0);
         check("dis_aack", c_a_ack, 0);
         check("dis_sel", c_sel, 0);
         check("dis_valid", c_b_valid, 1);
         check("dis_data", c_b_rdata, 8'hA5);
         step(); #1;
      end
      en = 1'b1; b_req = 1'b0; #1;
      check("en_valid", c_b_valid, 1);
      check("en_idle_sel", c_sel, 0);
      step(); #1;
      check("en_valid_drop", c_b_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
